// File: rtl/canvas_pkg.sv
`default_nettype none
// ============================================================================
// Module   : canvas_pkg
// Purpose  : Shared state encoding, colour type and cursor geometry for the
//            canvas store.
// Revision : 1.0
// ============================================================================
package canvas_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STAMP = 2'd1,
        CLEAR = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int C_COLOR_W = 3;
    typedef logic [C_COLOR_W-1:0] color_t;

    // Cursor outline sits this many pixels from its centre
    localparam int C_CURSOR_HALF = 2;

endpackage
`default_nettype wire

// File: rtl/canvas_ram.sv
`default_nettype none
// ============================================================================
// Module   : canvas_ram
// Purpose  : Simple dual-port RAM, one write port and one registered read port;
//            a same-address read and write returns the old data.
// Revision : 1.0
// ============================================================================
module canvas_ram #(
    parameter int DEPTH  = 40000,
    parameter int WIDTH  = 3,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem_q[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem_q[i_raddr];
    end

endmodule
`default_nettype wire

// File: rtl/canvas_store.sv
`default_nettype none
// ============================================================================
// Module   : canvas_store
// Purpose  : Colour frame store with a registered VGA read port and a
//            stamp/clear write engine retiring one pixel per cycle.
//            Optional cursor outline overlay: define CURSOR_OVERLAY_EN.
// Revision : 1.0
// ============================================================================
module canvas_store
    import canvas_pkg::*;
#(
    parameter int CANVAS_W     = 200,
    parameter int CANVAS_H     = 200,
    parameter int COLOR_W      = 3,
    parameter int COORD_W      = 10,
    parameter int RAD_W        = 3,
    parameter int BORDER_COLOR = 0,
    parameter int CURSOR_COLOR = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COORD_W-1:0] rx,
    input  logic [COORD_W-1:0] ry,
    output logic [COLOR_W-1:0] colorCode,
    input  logic               stamp_req,
    input  logic [COORD_W-1:0] stamp_x,
    input  logic [COORD_W-1:0] stamp_y,
    input  logic [RAD_W-1:0]   stamp_r,
    input  logic [COLOR_W-1:0] stamp_color,
    input  logic               clear_req,
    input  logic [COLOR_W-1:0] clear_color,
    output logic               ready,
    output logic               done,
    input  logic [COORD_W-1:0] cursor_x,
    input  logic [COORD_W-1:0] cursor_y
);

    localparam int c_depth  = CANVAS_W * CANVAS_H;
    localparam int c_addr_w = $clog2(c_depth);
    localparam int c_sw     = COORD_W + 2;
    localparam logic [COORD_W:0]         c_w_lim = (COORD_W+1)'(CANVAS_W);
    localparam logic [COORD_W:0]         c_h_lim = (COORD_W+1)'(CANVAS_H);
    localparam logic signed [c_sw-1:0]   c_x_max = c_sw'(CANVAS_W - 1);
    localparam logic signed [c_sw-1:0]   c_y_max = c_sw'(CANVAS_H - 1);
    localparam logic [c_addr_w-1:0]      c_last  = c_addr_w'(c_depth - 1);

    state_t                r_state_q, w_state_d;
    logic [COORD_W-1:0]    r_x_q, w_x_d, r_y_q, w_y_d;
    logic [COORD_W-1:0]    r_xs_q, w_xs_d, r_xe_q, w_xe_d, r_ye_q, w_ye_d;
    logic [c_addr_w-1:0]   r_addr_q, w_addr_d;
    logic [COLOR_W-1:0]    r_color_q, w_color_d;
    logic                  r_empty_q, w_empty_d;
    logic                  r_oob_q, w_oob_d;

    logic signed [c_sw-1:0] w_cx, w_cy, w_rad, w_sxs, w_sxe, w_sys, w_sye;
    logic                   w_we;
    logic [c_addr_w-1:0]    w_waddr, w_raddr;
    logic [COLOR_W-1:0]     w_rdata;

    // Stamp window clipped against the canvas in signed arithmetic
    always_comb begin
        w_cx  = $signed({2'b00, stamp_x});
        w_cy  = $signed({2'b00, stamp_y});
        w_rad = $signed({{(c_sw-RAD_W){1'b0}}, stamp_r});
        w_sxs = w_cx - w_rad;
        w_sxe = w_cx + w_rad;
        w_sys = w_cy - w_rad;
        w_sye = w_cy + w_rad;
        if (w_sxs[c_sw-1]) w_sxs = '0;
        if (w_sys[c_sw-1]) w_sys = '0;
        if (w_sxe > c_x_max) w_sxe = c_x_max;
        if (w_sye > c_y_max) w_sye = c_y_max;
    end

    always_comb begin
        w_state_d = r_state_q;
        w_x_d     = r_x_q;
        w_y_d     = r_y_q;
        w_xs_d    = r_xs_q;
        w_xe_d    = r_xe_q;
        w_ye_d    = r_ye_q;
        w_addr_d  = r_addr_q;
        w_color_d = r_color_q;
        w_empty_d = r_empty_q;
        w_we      = 1'b0;
        w_waddr   = r_addr_q;
        ready     = 1'b0;
        done      = 1'b0;
        case (r_state_q)
            IDLE: begin
                ready = 1'b1;
                if (clear_req) begin
                    w_state_d = CLEAR;
                    w_color_d = clear_color;
                    w_addr_d  = '0;
                end else if (stamp_req) begin
                    w_state_d = STAMP;
                    w_color_d = stamp_color;
                    w_empty_d = (w_sxs > w_sxe) || (w_sys > w_sye);
                    w_x_d     = w_sxs[COORD_W-1:0];
                    w_y_d     = w_sys[COORD_W-1:0];
                    w_xs_d    = w_sxs[COORD_W-1:0];
                    w_xe_d    = w_sxe[COORD_W-1:0];
                    w_ye_d    = w_sye[COORD_W-1:0];
                end
            end
            STAMP: begin
                if (r_empty_q) begin
                    w_state_d = DONE;
                end else begin
                    w_we    = 1'b1;
                    w_waddr = c_addr_w'(32'(r_y_q) * 32'(CANVAS_W) + 32'(r_x_q));
                    if (r_x_q == r_xe_q) begin
                        if (r_y_q == r_ye_q) begin
                            w_state_d = DONE;
                        end else begin
                            w_x_d = r_xs_q;
                            w_y_d = r_y_q + 1'b1;
                        end
                    end else begin
                        w_x_d = r_x_q + 1'b1;
                    end
                end
            end
            CLEAR: begin
                w_we = 1'b1;
                if (r_addr_q == c_last) begin
                    w_addr_d  = '0;
                    w_state_d = DONE;
                end else begin
                    w_addr_d = r_addr_q + 1'b1;
                end
            end
            DONE: begin
                done      = 1'b1;
                w_state_d = IDLE;
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_comb begin
        w_oob_d = !(({1'b0, rx} < c_w_lim) && ({1'b0, ry} < c_h_lim));
        w_raddr = w_oob_d ? '0 : c_addr_w'(32'(ry) * 32'(CANVAS_W) + 32'(rx));
    end

`ifdef CURSOR_OVERLAY_EN
    logic                      r_hit_q, w_hit_d;
    logic signed [COORD_W:0]   w_dx, w_dy;
    logic [COORD_W:0]          w_adx, w_ady;
    localparam logic [COORD_W:0] c_half = (COORD_W+1)'(C_CURSOR_HALF);

    always_comb begin
        w_dx    = $signed({1'b0, rx}) - $signed({1'b0, cursor_x});
        w_dy    = $signed({1'b0, ry}) - $signed({1'b0, cursor_y});
        w_adx   = w_dx[COORD_W] ? -w_dx : w_dx;
        w_ady   = w_dy[COORD_W] ? -w_dy : w_dy;
        w_hit_d = ((w_adx == c_half) && (w_ady <= c_half)) ||
                  ((w_ady == c_half) && (w_adx <= c_half));
    end
`else
    logic w_unused_cursor;
    assign w_unused_cursor = ^{cursor_x, cursor_y, COLOR_W'(CURSOR_COLOR)};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q <= IDLE;
            r_x_q     <= '0;
            r_y_q     <= '0;
            r_xs_q    <= '0;
            r_xe_q    <= '0;
            r_ye_q    <= '0;
            r_addr_q  <= '0;
            r_color_q <= '0;
            r_empty_q <= 1'b0;
            r_oob_q   <= 1'b1;
`ifdef CURSOR_OVERLAY_EN
            r_hit_q   <= 1'b0;
`endif
        end else begin
            r_state_q <= w_state_d;
            r_x_q     <= w_x_d;
            r_y_q     <= w_y_d;
            r_xs_q    <= w_xs_d;
            r_xe_q    <= w_xe_d;
            r_ye_q    <= w_ye_d;
            r_addr_q  <= w_addr_d;
            r_color_q <= w_color_d;
            r_empty_q <= w_empty_d;
            r_oob_q   <= w_oob_d;
`ifdef CURSOR_OVERLAY_EN
            r_hit_q   <= w_hit_d;
`endif
        end
    end

    // Border beats overlay, overlay beats RAM data
    always_comb begin
        colorCode = w_rdata;
`ifdef CURSOR_OVERLAY_EN
        if (r_hit_q) colorCode = COLOR_W'(CURSOR_COLOR);
`endif
        if (r_oob_q) colorCode = COLOR_W'(BORDER_COLOR);
    end

    canvas_ram #(
        .DEPTH  (c_depth),
        .WIDTH  (COLOR_W),
        .ADDR_W (c_addr_w)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (r_color_q),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_canvas_store.sv
`default_nettype none
// ============================================================================
// Module   : tb_canvas_store
// Purpose  : Directed, table-driven bench for canvas_store (default 200x200).
//            Cursor expectations follow CURSOR_OVERLAY_EN when defined.
// Revision : 1.0
// ============================================================================
module tb_canvas_store;

    logic       clk;
    logic       reset;
    logic [9:0] rx, ry;
    logic [2:0] colorCode;
    logic       stamp_req;
    logic [9:0] stamp_x, stamp_y;
    logic [2:0] stamp_r;
    logic [2:0] stamp_color;
    logic       clear_req;
    logic [2:0] clear_color;
    logic       ready, done;
    logic [9:0] cursor_x, cursor_y;

`ifdef CURSOR_OVERLAY_EN
    localparam int c_ov = 7;
`else
    localparam int c_ov = 2;
`endif

    canvas_store dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .ry          (ry),
        .colorCode   (colorCode),
        .stamp_req   (stamp_req),
        .stamp_x     (stamp_x),
        .stamp_y     (stamp_y),
        .stamp_r     (stamp_r),
        .stamp_color (stamp_color),
        .clear_req   (clear_req),
        .clear_color (clear_color),
        .ready       (ready),
        .done        (done),
        .cursor_x    (cursor_x),
        .cursor_y    (cursor_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int phase;
        int x;
        int y;
        int exp;
    } rd_vec_t;

    rd_vec_t vecs[$];
    int      n_pass  = 0;
    int      n_total = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic add(input int ph, input int x, input int y, input int e);
        rd_vec_t v;
        v.phase = ph; v.x = x; v.y = y; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic run_phase(input int ph);
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].phase == ph) begin
                rx = 10'(vecs[i].x);
                ry = 10'(vecs[i].y);
                tick();
                chk($sformatf("read p%0d (%0d,%0d)", ph, vecs[i].x, vecs[i].y),
                    32'(colorCode), 32'(vecs[i].exp));
            end
        end
    endtask

    // Called one cycle after the accepting edge; cnt counts cycles from accept
    task automatic wait_done(input string nm, input int exp_cycles);
        int cnt = 1;
        bit busy_bad = 1'b0;
        while (done !== 1'b1 && cnt < 45000) begin
            if (cnt == 5) stamp_req = 1'b0;
            if (ready !== 1'b0) busy_bad = 1'b1;
            tick();
            cnt++;
        end
        chk({nm, " done latency"}, 32'(cnt), 32'(exp_cycles));
        chk({nm, " ready low while busy"}, 32'(busy_bad | ready), 32'd0);
        tick();
        chk({nm, " done single pulse"}, 32'(done), 32'd0);
        chk({nm, " ready back"}, 32'(ready), 32'd1);
    endtask

    task automatic issue_stamp(input int x, input int y, input int r, input int col);
        stamp_x = 10'(x); stamp_y = 10'(y); stamp_r = 3'(r); stamp_color = 3'(col);
        stamp_req = 1'b1;
        tick();
        stamp_req = 1'b0;
        stamp_x = 10'd0; stamp_y = 10'd0; stamp_r = 3'd0; stamp_color = 3'd1;
    endtask

    task automatic issue_clear(input int col);
        clear_color = 3'(col);
        clear_req   = 1'b1;
        tick();
        clear_req   = 1'b0;
        clear_color = 3'd1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; rx = '0; ry = '0;
        stamp_req = 1'b0; stamp_x = '0; stamp_y = '0; stamp_r = '0; stamp_color = '0;
        clear_req = 1'b0; clear_color = '0;
        cursor_x = 10'd600; cursor_y = 10'd600;

        // phase 1: after clear to 5
        add(1, 0, 0, 5);     add(1, 199, 0, 5);   add(1, 0, 199, 5);
        add(1, 199, 199, 5); add(1, 100, 57, 5);  add(1, 250, 10, 0);
        add(1, 10, 250, 0);  add(1, 200, 199, 0);
        // phase 2: stamp (100,100) r2 colour 3
        add(2, 98, 98, 3);   add(2, 102, 102, 3); add(2, 100, 100, 3);
        add(2, 98, 102, 3);  add(2, 102, 98, 3);  add(2, 97, 100, 5);
        add(2, 103, 100, 5); add(2, 100, 97, 5);  add(2, 100, 103, 5);
        // phase 3: stamp (1,0) r3 colour 6 clipped to x 0..4, y 0..3
        add(3, 0, 0, 6);     add(3, 4, 3, 6);     add(3, 1, 0, 6);
        add(3, 5, 0, 5);     add(3, 0, 4, 5);     add(3, 199, 0, 5);
        add(3, 199, 199, 5); add(3, 0, 199, 5);   add(3, 199, 3, 5);
        // phase 4: fully clipped stamp (205,50) leaves nothing behind
        add(4, 199, 50, 5);  add(4, 199, 48, 5);  add(4, 3, 51, 5);
        add(4, 4, 51, 5);
        // phase 5: clear 2 won over simultaneous stamp (10,10) colour 7
        add(5, 10, 10, 2);   add(5, 9, 9, 2);     add(5, 11, 11, 2);
        add(5, 0, 0, 2);     add(5, 100, 100, 2); add(5, 199, 199, 2);
        // phase 6: clear 4 aborted after addresses 0..999
        add(6, 0, 0, 4);     add(6, 199, 4, 4);   add(6, 0, 5, 2);
        add(6, 1, 5, 2);     add(6, 199, 199, 2);
        // phase 7: cursor at (50,50)
        add(7, 48, 50, c_ov); add(7, 50, 50, 2);   add(7, 53, 50, 2);
        add(7, 52, 52, c_ov); add(7, 48, 48, c_ov); add(7, 51, 48, c_ov);
        add(7, 49, 49, 2);    add(7, 50, 53, 2);

        tick(); tick();
        chk("reset ready", 32'(ready), 32'd1);
        chk("reset done", 32'(done), 32'd0);
        chk("reset colorCode", 32'(colorCode), 32'd0);
        reset = 1'b0;
        tick();

        issue_clear(5);
        wait_done("clear5", 40001);
        run_phase(1);

        issue_stamp(100, 100, 2, 3);
        wait_done("stamp r2", 26);
        run_phase(2);

        issue_stamp(1, 0, 3, 6);
        wait_done("stamp clip", 21);
        run_phase(3);

        issue_stamp(205, 50, 2, 4);
        wait_done("stamp empty", 2);
        run_phase(4);

        // Simultaneous requests, stamp held while busy then dropped
        stamp_x = 10'd10; stamp_y = 10'd10; stamp_r = 3'd1; stamp_color = 3'd7;
        clear_color = 3'd2;
        stamp_req = 1'b1; clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        wait_done("clear+stamp", 40001);
        tick();
        chk("no queued stamp ready", 32'(ready), 32'd1);
        chk("no queued stamp done", 32'(done), 32'd0);
        run_phase(5);

        issue_clear(4);
        for (int i = 0; i < 1000; i++) tick();
        chk("mid-clear busy", 32'(ready), 32'd0);
        reset = 1'b1;
        #1;
        chk("async reset ready", 32'(ready), 32'd1);
        chk("async reset colorCode", 32'(colorCode), 32'd0);
        chk("async reset done", 32'(done), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        run_phase(6);

        cursor_x = 10'd50; cursor_y = 10'd50;
        run_phase(7);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
